// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the data memory responder
package dm_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dm_access_check.sv
// rtl/dm_access_check.sv - alignment and range legality of a memory access
module dm_access_check
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    output logic        legal
);

    logic        be_ok;
    logic        range_ok;
    logic [31:0] idx_ext;

    // Byte-enable pattern must match the byte offset; the word index must be in range.
    always_comb begin
        be_ok = 1'b0;
        if (be == BE_WORD) begin
            be_ok = (addr[1:0] == 2'b00);
        end else if (be == BE_HALF_LO) begin
            be_ok = (addr[1:0] == 2'b00);
        end else if (be == BE_HALF_HI) begin
            be_ok = (addr[1:0] == 2'b10);
        end else begin
            be_ok = (be == (4'b0001 << addr[1:0]));
        end
        idx_ext  = {2'b00, addr[31:2]};
        range_ok = (idx_ext < 32'(DEPTH_WORDS));
        legal    = be_ok && range_ok;
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - request/response data memory with programmable wait states
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dm_state_t          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               ready_n, valid_n, err_n;
    logic [31:0]        rdata_n;
    logic               cap_en;
    logic               cap_write;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [3:0]         cap_be;
    logic               legal;
    logic               commit;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem [DEPTH_WORDS];

    dm_access_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_check (
        .addr  (cap_addr),
        .be    (cap_be),
        .legal (legal)
    );

    assign idx    = cap_addr[IDX_W+1:2];
    assign commit = (state == DM_WAIT) && (cnt == '0) && legal && cap_write;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready_n = req_ready;
        valid_n = resp_valid;
        rdata_n = resp_rdata;
        err_n   = resp_err;
        cap_en  = 1'b0;
        case (state)
            DM_IDLE: begin
                if (req_valid && req_ready) begin
                    state_n = DM_WAIT;
                    cnt_n   = CNT_W'(LATENCY - 1);
                    ready_n = 1'b0;
                    cap_en  = 1'b1;
                end
            end
            DM_WAIT: begin
                if (cnt == '0) begin
                    state_n = DM_RESP;
                    valid_n = 1'b1;
                    err_n   = !legal;
                    rdata_n = (legal && !cap_write) ? mem[idx] : 32'h0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DM_RESP: begin
                if (resp_ready) begin
                    state_n = DM_IDLE;
                    valid_n = 1'b0;
                    rdata_n = 32'h0;
                    err_n   = 1'b0;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = DM_IDLE;
                ready_n = 1'b1;
                valid_n = 1'b0;
                rdata_n = 32'h0;
                err_n   = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset drops any transaction in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= DM_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            cap_write  <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            cap_be     <= 4'h0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req_ready  <= ready_n;
            resp_valid <= valid_n;
            resp_rdata <= rdata_n;
            resp_err   <= err_n;
            if (cap_en) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end
        end
    end

    // Storage is never cleared; a store lands only on the WAIT->RESP edge.
    always_ff @(posedge Clk) begin
        if (commit) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (cap_be[lane]) begin
                    mem[idx][lane*8 +: 8] <= cap_wdata[lane*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] model [int];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    always #5 Clk = ~Clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit m_legal(input logic [31:0] a, input logic [3:0] be);
        int unsigned word;
        int unsigned off;
        word = a / 4;
        off  = a % 4;
        if (word >= DEPTH) return 1'b0;
        if (be == 4'b1111) return off == 0;
        if (be == 4'b0011) return off == 0;
        if (be == 4'b1100) return off == 2;
        return be == 4'(1 << off);
    endfunction

    task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic [31:0] rd, output logic er);
        int          word;
        logic [31:0] tmp;
        word = int'(a / 4);
        rd = 32'h0;
        er = 1'b0;
        if (!m_legal(a, be)) begin
            er = 1'b1;
        end else if (w) begin
            tmp = model.exists(word) ? model[word] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (be[i]) tmp[i*8 +: 8] = d[i*8 +: 8];
            model[word] = tmp;
        end else begin
            rd = model.exists(word) ? model[word] : 32'hxxxxxxxx;
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        req_valid = 1'b1;
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge Clk);
        resp_ready = 1'b0;
        check("post_hs_ready", 32'(req_ready), 32'd1);
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_rdata", resp_rdata, 32'h0);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input int hold, output logic [31:0] rd, output logic er, output int lat);
        issue(w, a, d, be);
        wait_ready();
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (lat == 1) req_valid = 1'b0;
        end while (resp_valid !== 1'b1 && lat < 50);
        if (lat >= 50) check("resp_timeout", 32'(resp_valid), 32'd1);
        rd = resp_rdata;
        er = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, rd);
            check("hold_err", 32'(resp_err), 32'(er));
        end
        handshake();
    endtask

    initial begin
        logic [31:0] rd, mrd, a, d;
        logic        er, mer, w;
        logic [3:0]  be;
        int          lat, guard, word;

        repeat (3) @(negedge Clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h12,   32'h00AB0000, 4'b0100, 0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 0, 32'hDEABBEEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h12,   32'h12345678, 4'b0011, 0, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h11,   32'h12345678, 4'b1111, 0, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h10,   32'h0,        4'b1111, 0, 32'hDEABBEEF, 1'b0};
        vecs[7]  = '{1'b0, 32'h1000, 32'h0,        4'b1111, 5, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h12,   32'h0,        4'b1100, 5, 32'hDEABBEEF, 1'b0};
        vecs[9]  = '{1'b0, 32'h10,   32'h0,        4'b0000, 0, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h14,   32'hCAFEF00D, 4'b1111, 0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h17,   32'h0,        4'b1000, 0, 32'hCAFEF00D, 1'b0};
        vecs[12] = '{1'b0, 32'h16,   32'h0,        4'b0001, 0, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 32'hFFC,  32'hA5A5A5A5, 4'b1111, 0, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 32'hFFC,  32'h0,        4'b1111, 0, 32'hA5A5A5A5, 1'b0};
        vecs[15] = '{1'b1, 32'h1004, 32'hFFFFFFFF, 4'b1111, 0, 32'h0,        1'b1};

        for (int i = 0; i < 16; i++) begin
            txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, vecs[i].hold, rd, er, lat);
            model_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, mrd, mer);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT + 1));
        end

        // Reset while a store sits in WAIT: nothing is committed.
        txn(1'b1, 32'h20, 32'h11223344, 4'b1111, 0, rd, er, lat);
        model_txn(1'b1, 32'h20, 32'h11223344, 4'b1111, mrd, mer);
        issue(1'b1, 32'h20, 32'h55555555, 4'b1111);
        wait_ready();
        @(negedge Clk);
        req_valid = 1'b0;
        Rst = 1'b0;
        #1;
        check("rstwait_req_ready", 32'(req_ready), 32'd1);
        check("rstwait_resp_valid", 32'(resp_valid), 32'd0);
        check("rstwait_rdata", resp_rdata, 32'h0);
        check("rstwait_err", 32'(resp_err), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        txn(1'b0, 32'h20, 32'h0, 4'b1111, 0, rd, er, lat);
        check("rstwait_load", rd, 32'h11223344);

        // Reset while a store sits in RESP: the store stays written.
        issue(1'b1, 32'h24, 32'h66666666, 4'b1111);
        wait_ready();
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
            req_valid = 1'b0;
        end while (resp_valid !== 1'b1 && guard < 50);
        Rst = 1'b0;
        #1;
        check("rstresp_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        model_txn(1'b1, 32'h24, 32'h66666666, 4'b1111, mrd, mer);
        @(negedge Clk);
        txn(1'b0, 32'h24, 32'h0, 4'b1111, 0, rd, er, lat);
        check("rstresp_load", rd, 32'h66666666);

        // req_valid held high with wandering address while busy must be ignored.
        issue(1'b0, 32'h10, 32'h0, 4'b1111);
        wait_ready();
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
            if (resp_valid !== 1'b1) check("busy_ready_low", 32'(req_ready), 32'd0);
            req_write = 1'b1;
            req_addr  = 32'($urandom_range(0, 15)) * 4;
            req_wdata = $urandom;
        end while (resp_valid !== 1'b1 && guard < 50);
        check("busy_first_rdata", resp_rdata, 32'hDEABBEEF);
        repeat (2) begin
            @(negedge Clk);
            check("busy_resp_ready_low", 32'(req_ready), 32'd0);
        end
        issue(1'b0, 32'h14, 32'h0, 4'b1111);
        resp_ready = 1'b1;
        @(negedge Clk);
        resp_ready = 1'b0;
        check("busy_idle_ready", 32'(req_ready), 32'd1);
        check("busy_idle_valid", 32'(resp_valid), 32'd0);
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            req_valid = 1'b0;
        end while (resp_valid !== 1'b1 && lat < 50);
        check("busy_second_lat", 32'(lat), 32'(LAT + 1));
        check("busy_second_rdata", resp_rdata, 32'hCAFEF00D);
        handshake();
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 0, rd, er, lat);
        check("busy_mem_intact", rd, 32'hDEABBEEF);

        // Randomised traffic against the reference model over a small window.
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            txn(1'b1, 32'(i * 4), d, 4'b1111, 0, rd, er, lat);
            model_txn(1'b1, 32'(i * 4), d, 4'b1111, mrd, mer);
        end
        for (int n = 0; n < 200; n++) begin
            w    = 1'($urandom_range(0, 1));
            word = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) word = DEPTH + $urandom_range(0, 100);
            a = 32'(word) * 4 + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: be = 4'b1111;
                1: be = 4'b0011;
                2: be = 4'b1100;
                3: be = 4'(1 << $urandom_range(0, 3));
                default: be = 4'($urandom_range(0, 15));
            endcase
            d = $urandom;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
            model_txn(w, a, d, be, mrd, mer);
            txn(w, a, d, be, $urandom_range(0, 3), rd, er, lat);
            check($sformatf("rand%0d_rdata", n), rd, mrd);
            check($sformatf("rand%0d_err", n), 32'(er), 32'(mer));
            check($sformatf("rand%0d_lat", n), 32'(lat), 32'(LAT + 1));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
